// File: rtl/input_cmd_merge.sv
// input_cmd_merge
//   Front-end that merges debounced push buttons and slide switches with UART
//   keyboard commands. Produces one-cycle button pulses, effective switch
//   levels (physical level XOR a UART toggle) and a system reset that is the
//   OR of rst and a stretched ESC reset.
//
//   Optional feature macro: CASE_FOLD_EN
//     defined   -> received bytes 'a'..'z' are folded to upper case before the
//                  key match (key parameters must be upper case)
//     undefined -> exact 8-bit compare
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   btn_in     raw asynchronous push buttons   [NUM_BTN]
//   sw_in      raw asynchronous slide switches [NUM_SW]
//   rx_data    received UART byte, valid with rx_done
//   rx_done    one-cycle strobe for rx_data
//   btn_pulse  one-cycle press pulse per button (registered)
//   sw_out     effective switch level
//   sys_rst    rst OR stretched ESC reset (RST_CYC cycles)
//
// Key strings: byte i (byte 0 = LSB) is the key for channel i, so the default
// "DURL" maps L,R,U,D to buttons 0..3 and "SM" maps M,S to switches 0..1.

// Per-channel 2-FF synchroniser plus debounce filter.
module debounce_ch #(
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // cnt counts consecutive mismatch cycles; the DEBOUNCE_CYC-th one commits
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module input_cmd_merge #(
  parameter int                   NUM_BTN      = 4,
  parameter int                   NUM_SW       = 2,
  parameter int                   DEBOUNCE_CYC = 100000,
  parameter logic [8*NUM_BTN-1:0] BTN_KEYS     = "DURL",
  parameter logic [8*NUM_SW-1:0]  SW_KEYS      = "SM",
  parameter logic [7:0]           ESC_KEY      = 8'h1B,
  parameter int                   RST_CYC      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_SW-1:0]  sw_out,
  output logic               sys_rst
);
  localparam int EW = $clog2(RST_CYC + 1);
  localparam logic [EW-1:0] ESC_LOAD = EW'(RST_CYC);

  logic [NUM_BTN-1:0] btn_stable, btn_prev, btn_hit;
  logic [NUM_SW-1:0]  sw_stable, sw_hit, tog;
  logic [EW-1:0]      esc_cnt;
  logic [7:0]         key;
  logic               esc_hit, uart_ok, btn_any, sw_any;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_ch #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk), .rst(rst), .raw(btn_in[g]), .stable(btn_stable[g]));
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    debounce_ch #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk), .rst(rst), .raw(sw_in[g]), .stable(sw_stable[g]));
  end

  // UART decode: ESC beats buttons beats switches; lowest index wins in a class.
  always_comb begin
    key = rx_data;
`ifdef CASE_FOLD_EN
    if (rx_data >= 8'h61 && rx_data <= 8'h7A) key = rx_data & 8'hDF;
`endif
    esc_hit = rx_done && (key == ESC_KEY);
    // button/switch commands are locked out while the ESC stretch runs
    uart_ok = rx_done && !esc_hit && (esc_cnt == '0);
    btn_hit = '0;
    sw_hit  = '0;
    btn_any = 1'b0;
    sw_any  = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!btn_any && key == BTN_KEYS[8*i +: 8]) begin
        btn_hit[i] = 1'b1;
        btn_any    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_SW; j++) begin
      if (!sw_any && key == SW_KEYS[8*j +: 8]) begin
        sw_hit[j] = 1'b1;
        sw_any    = 1'b1;
      end
    end
    if (!uart_ok)           btn_hit = '0;
    if (!uart_ok || btn_any) sw_hit  = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev  <= '0;
      btn_pulse <= '0;
      tog       <= '0;
      esc_cnt   <= '0;
    end else begin
      btn_prev  <= btn_stable;
      // rising edge of the debounced level OR a UART hit -> single pulse
      btn_pulse <= (btn_stable & ~btn_prev) | btn_hit;
      if (esc_hit)             esc_cnt <= ESC_LOAD;
      else if (esc_cnt != '0)  esc_cnt <= esc_cnt - EW'(1);
      if (esc_hit || esc_cnt != '0) tog <= '0;
      else                          tog <= tog ^ sw_hit;
    end
  end

  assign sw_out  = sw_stable ^ tog;
  assign sys_rst = rst | (esc_cnt != '0);
endmodule
